hazard_controller: RTL and testbench

- Pipeline hazard and stall sequencer for the 5-stage core. Sits beside the ID and EX stages.
- Detects load-use hazards and inserts a single-cycle bubble. Squashes the wrong-path instruction on a taken branch.
- Holds the front of the pipe while a multi-cycle mul/div occupies EX. Keeps a saturating stall-cycle performance counter.
- Operand forwarding is handled inside the EX stage. This block only generates pipeline-register write enables, holds and bubbles.

---
 rtl/hazard_controller.sv | 115 +++++++++++
 tb/tb_hazard_controller.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_controller.sv
// Pipeline hazard and stall sequencer for the 5-stage core.
// Produces pipe-register enables, holds and bubbles beside ID/EX.
module hazard_controller #(
  parameter int MULDIV_LATENCY = 4,
  parameter int CNT_W          = 3
) (
  input  logic        Clk,
  input  logic        ResetN,
  input  logic        IDValid,
  input  logic [4:0]  IDRs,
  input  logic [4:0]  IDRt,
  input  logic        IDUsesRt,
  input  logic        IDMulDiv,
  input  logic        EXMemRead,
  input  logic [4:0]  EXRd,
  input  logic        BranchTaken,
  output logic        PCWrite,
  output logic        IFIDWrite,
  output logic        IFIDFlush,
  output logic        IDEXBubble,
  output logic        IDEXHold,
  output logic        EXMEMBubble,
  output logic        MulDivBusy,
  output logic [15:0] StallCycles
);

  typedef enum logic {
    RUN,
    MULDIV
  } state_t;

  localparam bit MultiCycle = MULDIV_LATENCY > 1;
  localparam logic [CNT_W-1:0] CntLoad = CNT_W'(MULDIV_LATENCY - 1);
  localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);

  state_t           state;
  logic [CNT_W-1:0] cnt;

  logic rsHit;
  logic rtHit;
  logic loadUse;
  logic issue;

  assign rsHit   = EXRd == IDRs;
  assign rtHit   = IDUsesRt & (EXRd == IDRt);
  assign loadUse = IDValid & EXMemRead & (EXRd != 5'd0)
                 & (rsHit | rtHit);

  // A squashed or stalled ID instruction must not start a mul/div.
  assign issue = MultiCycle & IDValid & IDMulDiv
               & ~BranchTaken & ~loadUse;

  always_comb begin
    PCWrite     = 1'b1;
    IFIDWrite   = 1'b1;
    IFIDFlush   = 1'b0;
    IDEXBubble  = 1'b0;
    IDEXHold    = 1'b0;
    EXMEMBubble = 1'b0;
    MulDivBusy  = 1'b0;
    if (ResetN) begin
      unique case (state)
        RUN: begin
          priority case (1'b1)
            BranchTaken: begin
              IFIDFlush  = 1'b1;
              IDEXBubble = 1'b1;
            end
            loadUse: begin
              PCWrite    = 1'b0;
              IFIDWrite  = 1'b0;
              IDEXBubble = 1'b1;
            end
            default: ;
          endcase
        end
        MULDIV: begin
          PCWrite     = 1'b0;
          IFIDWrite   = 1'b0;
          IDEXHold    = 1'b1;
          EXMEMBubble = 1'b1;
          MulDivBusy  = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (!ResetN) begin
      state       <= RUN;
      cnt         <= '0;
      StallCycles <= '0;
    end else begin
      if (!PCWrite && StallCycles != 16'hFFFF)
        StallCycles <= StallCycles + 16'd1;
      unique case (state)
        RUN: begin
          if (issue) begin
            state <= MULDIV;
            cnt   <= CntLoad;
          end
        end
        MULDIV: begin
          if (cnt == CntOne) begin
            state <= RUN;
            cnt   <= '0;
          end else begin
            cnt <= cnt - CntOne;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hazard_controller.sv
// Self-checking bench for hazard_controller: vector table,
// hand sequences, randomized model compare and saturation.
module tb_hazard_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       resetN;
  logic       idValid;
  logic [4:0] idRs;
  logic [4:0] idRt;
  logic       idUsesRt;
  logic       idMulDiv;
  logic       exMemRead;
  logic [4:0] exRd;
  logic       branchTaken;

  wire [6:0]  obs0;
  wire [6:0]  obs1;
  wire [15:0] stall0;
  wire [15:0] stall1;

  hazard_controller #(
    .MULDIV_LATENCY(4),
    .CNT_W(3)
  ) dut0 (
    .Clk(clk),
    .ResetN(resetN),
    .IDValid(idValid),
    .IDRs(idRs),
    .IDRt(idRt),
    .IDUsesRt(idUsesRt),
    .IDMulDiv(idMulDiv),
    .EXMemRead(exMemRead),
    .EXRd(exRd),
    .BranchTaken(branchTaken),
    .PCWrite(obs0[6]),
    .IFIDWrite(obs0[5]),
    .IFIDFlush(obs0[4]),
    .IDEXBubble(obs0[3]),
    .IDEXHold(obs0[2]),
    .EXMEMBubble(obs0[1]),
    .MulDivBusy(obs0[0]),
    .StallCycles(stall0)
  );

  hazard_controller #(
    .MULDIV_LATENCY(1),
    .CNT_W(3)
  ) dut1 (
    .Clk(clk),
    .ResetN(resetN),
    .IDValid(idValid),
    .IDRs(idRs),
    .IDRt(idRt),
    .IDUsesRt(idUsesRt),
    .IDMulDiv(idMulDiv),
    .EXMemRead(exMemRead),
    .EXRd(exRd),
    .BranchTaken(branchTaken),
    .PCWrite(obs1[6]),
    .IFIDWrite(obs1[5]),
    .IFIDFlush(obs1[4]),
    .IDEXBubble(obs1[3]),
    .IDEXHold(obs1[2]),
    .EXMEMBubble(obs1[1]),
    .MulDivBusy(obs1[0]),
    .StallCycles(stall1)
  );

  // {PCWrite,IFIDWrite,IFIDFlush,IDEXBubble,IDEXHold,EXMEMBubble,Busy}
  localparam logic [6:0] IDLE = 7'b1100000;
  localparam logic [6:0] LUO  = 7'b0001000;
  localparam logic [6:0] BRO  = 7'b1111000;
  localparam logic [6:0] MDO  = 7'b0000111;

  typedef struct {
    logic       rstN;
    logic       v;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       ur;
    logic       md;
    logic       mr;
    logic [4:0] rd;
    logic       br;
    logic [6:0] expO;
    int         expStall;
  } vec_t;

  int passCnt = 0;
  int totalCnt = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    totalCnt++;
    if (act === exp) passCnt++;
    else $display("FAIL %s: actual %0h required %0h", nm, act, exp);
  endtask

  task automatic drive(input logic rstN, input logic v,
                       input logic [4:0] rs, input logic [4:0] rt,
                       input logic ur, input logic md,
                       input logic mr, input logic [4:0] rd,
                       input logic br);
    resetN      = rstN;
    idValid     = v;
    idRs        = rs;
    idRt        = rt;
    idUsesRt    = ur;
    idMulDiv    = md;
    exMemRead   = mr;
    exRd        = rd;
    branchTaken = br;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(logic rstN, logic v, logic [4:0] rs,
                              logic [4:0] rt, logic ur, logic md,
                              logic mr, logic [4:0] rd, logic br,
                              logic [6:0] expO, int expStall);
    vec_t t;
    t.rstN = rstN; t.v = v; t.rs = rs; t.rt = rt; t.ur = ur;
    t.md = md; t.mr = mr; t.rd = rd; t.br = br;
    t.expO = expO; t.expStall = expStall;
    return t;
  endfunction

  function automatic bit luF(logic v, logic mr, logic [4:0] rd,
                             logic [4:0] rs, logic [4:0] rt,
                             logic ur);
    return v && mr && rd != 0 && (rd == rs || (ur && rd == rt));
  endfunction

  function automatic logic [6:0] expOut(bit rstN, bit busy,
                                        bit br, bit lu);
    if (!rstN) return IDLE;
    if (busy)  return MDO;
    if (br)    return BRO;
    if (lu)    return LUO;
    return IDLE;
  endfunction

  vec_t tbl [14];

  int         lat [2];
  int         busyLast [2];
  int         mStall [2];
  int         cyc;
  logic [6:0] e [2];

  initial begin
    tbl[0]  = mk(0, 1, 3, 0, 0, 1, 1, 3, 0, IDLE, 0);
    tbl[1]  = mk(0, 1, 3, 0, 0, 1, 1, 3, 0, IDLE, 0);
    tbl[2]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, IDLE, 0);
    tbl[3]  = mk(1, 1, 3, 0, 0, 0, 1, 3, 0, LUO,  1);
    tbl[4]  = mk(1, 1, 3, 0, 0, 0, 0, 3, 0, IDLE, 1);
    tbl[5]  = mk(1, 1, 0, 0, 0, 0, 1, 0, 0, IDLE, 1);
    tbl[6]  = mk(1, 1, 7, 3, 0, 0, 1, 3, 0, IDLE, 1);
    tbl[7]  = mk(1, 1, 7, 3, 1, 0, 1, 3, 0, LUO,  2);
    tbl[8]  = mk(1, 1, 3, 0, 0, 0, 1, 3, 1, BRO,  2);
    tbl[9]  = mk(1, 1, 0, 0, 0, 1, 0, 0, 0, IDLE, 2);
    tbl[10] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, MDO,  3);
    tbl[11] = mk(1, 1, 3, 0, 0, 0, 1, 3, 1, MDO,  4);
    tbl[12] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, MDO,  5);
    tbl[13] = mk(1, 1, 0, 0, 0, 0, 0, 0, 0, IDLE, 5);

    for (int i = 0; i < 14; i++) begin
      drive(tbl[i].rstN, tbl[i].v, tbl[i].rs, tbl[i].rt, tbl[i].ur,
            tbl[i].md, tbl[i].mr, tbl[i].rd, tbl[i].br);
      #2;
      chk($sformatf("vec%0d.out", i), 32'(obs0), 32'(tbl[i].expO));
      tick();
      chk($sformatf("vec%0d.stall", i), 32'(stall0),
          32'(tbl[i].expStall));
    end

    // Reset in the middle of a mul/div.
    drive(1, 1, 0, 0, 0, 1, 0, 0, 0);
    #2; chk("rstmid.issue", 32'(obs0), 32'(IDLE));
    tick();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    #2; chk("rstmid.busy", 32'(obs0), 32'(MDO));
    tick();
    chk("rstmid.stall6", 32'(stall0), 32'd6);
    drive(0, 1, 0, 0, 0, 1, 0, 0, 0);
    #2; chk("rstmid.forced", 32'(obs0), 32'(IDLE));
    tick();
    chk("rstmid.stall0", 32'(stall0), 32'd0);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    #2; chk("rstmid.run", 32'(obs0), 32'(IDLE));
    tick();
    chk("rstmid.stallHold", 32'(stall0), 32'd0);

    // Latency 1: mul/div never stalls.
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 0, 0, 0, 1, 0, 0, 0);
      #2; chk($sformatf("lat1.out%0d", i), 32'(obs1), 32'(IDLE));
      tick();
    end
    chk("lat1.stall", 32'(stall1), 32'd0);

    // Randomized run against the model; cycle 0 resets both.
    lat[0] = 4;
    lat[1] = 1;
    for (int k = 0; k < 2; k++) begin
      busyLast[k] = -1;
      mStall[k]   = 0;
    end
    cyc = 0;
    for (int c = 0; c < 3000; c++) begin
      logic rN, v, ur, md, mr, br;
      logic [4:0] rs, rt, rd;
      bit lu;
      rN = !(c == 0 || $urandom_range(0, 39) == 0);
      v  = $urandom_range(0, 3) != 0;
      ur = 1'($urandom_range(0, 1));
      md = $urandom_range(0, 4) == 0;
      mr = $urandom_range(0, 2) == 0;
      br = $urandom_range(0, 5) == 0;
      rs = 5'($urandom_range(0, 3));
      rt = 5'($urandom_range(0, 3));
      rd = 5'($urandom_range(0, 3));
      drive(rN, v, rs, rt, ur, md, mr, rd, br);
      lu = luF(v, mr, rd, rs, rt, ur);
      for (int k = 0; k < 2; k++)
        e[k] = expOut(rN, cyc <= busyLast[k], br, lu);
      #2;
      chk($sformatf("rnd%0d.out0", c), 32'(obs0), 32'(e[0]));
      chk($sformatf("rnd%0d.out1", c), 32'(obs1), 32'(e[1]));
      for (int k = 0; k < 2; k++) begin
        if (!rN) begin
          busyLast[k] = -1;
          mStall[k]   = 0;
        end else begin
          if (!e[k][6] && mStall[k] < 65535) mStall[k]++;
          if (cyc > busyLast[k] && !br && !lu && v && md && lat[k] > 1)
            busyLast[k] = cyc + lat[k] - 1;
        end
      end
      cyc++;
      tick();
      chk($sformatf("rnd%0d.stall0", c), 32'(stall0), 32'(mStall[0]));
      chk($sformatf("rnd%0d.stall1", c), 32'(stall1), 32'(mStall[1]));
    end

    // Saturation with a permanent load-use condition.
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    drive(1, 1, 3, 0, 0, 0, 1, 3, 0);
    #2; chk("sat.out", 32'(obs0), 32'(LUO));
    repeat (65534) @(posedge clk);
    #1;
    chk("sat.65534", 32'(stall0), 32'd65534);
    tick();
    chk("sat.max", 32'(stall0), 32'hFFFF);
    repeat (4465) @(posedge clk);
    #1;
    chk("sat.hold0", 32'(stall0), 32'hFFFF);
    chk("sat.hold1", 32'(stall1), 32'hFFFF);
    chk("sat.stillStall", 32'(obs0), 32'(LUO));

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
